serial_subtractor: RTL and testbench

Digit-serial ripple-borrow subtractor computing ans = X - Y - bin over WIDTH/DIGIT clock cycles.
- Processes DIGIT bits per cycle, LSB digit first, carrying the borrow in a register between cycles.
- Parametrised successor to the fixed-width combinational ripple-borrow subtractors; trades latency for area in the lab datapath.
- Uses a start/busy/done handshake for use by multi-cycle controllers.

---
 rtl/serial_subtractor.sv | 119 +++++++++++
 tb/tb_serial_subtractor.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - digit-serial ripple-borrow subtractor, ans = X - Y - bin over WIDTH/DIGIT cycles
// Optional feature macro: SERIAL_SUB_SAT_EN (saturate ans to zero on final borrow).
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ans,
    output logic             borrow
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
            $error("serial_subtractor: DIGIT must divide WIDTH and WIDTH must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_cnt;
    logic [WIDTH-1:0]  r_x;
    logic [WIDTH-1:0]  r_y;
    logic              r_brw;
    logic [WIDTH-1:0]  r_ans;
    logic              r_borrow;

    logic [31:0]       w_base;
    logic [DIGIT-1:0]  w_xd;
    logic [DIGIT-1:0]  w_yd;
    logic [DIGIT-1:0]  w_diff;
    logic [DIGIT:0]    w_chain;
    logic              w_start_ok;
    logic              w_last;

    assign w_start_ok = start && (r_state != S_RUN);
    assign w_last     = (r_state == S_RUN) && (r_cnt == CW'(N - 1));

    assign w_base = 32'(r_cnt) * 32'(DIGIT);
    assign w_xd   = r_x[w_base +: DIGIT];
    assign w_yd   = r_y[w_base +: DIGIT];

    // Chain of full-subtractor cells; the borrow register feeds the LSB cell.
    assign w_chain[0] = r_brw;
    genvar gi;
    generate
        for (gi = 0; gi < DIGIT; gi++) begin : g_cell
            assign w_diff[gi]    = w_xd[gi] ^ w_yd[gi] ^ w_chain[gi];
            assign w_chain[gi+1] = (~w_xd[gi] & w_yd[gi]) |
                                   (~(w_xd[gi] ^ w_yd[gi]) & w_chain[gi]);
        end
    endgenerate

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_brw    <= 1'b0;
            r_ans    <= '0;
            r_borrow <= 1'b0;
        end else if (w_start_ok) begin
            r_x   <= X;
            r_y   <= Y;
            r_brw <= bin;
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_ans[w_base +: DIGIT] <= w_diff;
            r_brw                  <= w_chain[DIGIT];
            r_cnt                  <= r_cnt + 1'b1;
            if (w_last) begin
                r_borrow <= w_chain[DIGIT];
`ifdef SERIAL_SUB_SAT_EN
                if (w_chain[DIGIT]) begin
                    r_ans <= '0;
                end
`endif
            end
        end
    end

    assign busy   = (r_state == S_RUN);
    assign done   = (r_state == S_DONE);
    assign ans    = r_ans;
    assign borrow = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor at several WIDTH/DIGIT points
module tb_serial_subtractor;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] start_v;
    logic [7:0] X_d;
    logic [7:0] Y_d;
    logic       bin_d;
    logic [3:0] busy_v;
    logic [3:0] done_v;
    logic [3:0] brw_v;
    logic [7:0] a0;
    logic [7:0] a1;
    logic [4:0] a2;
    logic [3:0] a3;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] ans;
        logic       brw;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .X(X_d), .Y(Y_d), .bin(bin_d),
        .busy(busy_v[0]), .done(done_v[0]), .ans(a0), .borrow(brw_v[0]));
    serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .X(X_d), .Y(Y_d), .bin(bin_d),
        .busy(busy_v[1]), .done(done_v[1]), .ans(a1), .borrow(brw_v[1]));
    serial_subtractor #(.WIDTH(5), .DIGIT(1)) u_w5d1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .X(X_d[4:0]), .Y(Y_d[4:0]), .bin(bin_d),
        .busy(busy_v[2]), .done(done_v[2]), .ans(a2), .borrow(brw_v[2]));
    serial_subtractor #(.WIDTH(4), .DIGIT(2)) u_w4d2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .X(X_d[3:0]), .Y(Y_d[3:0]), .bin(bin_d),
        .busy(busy_v[3]), .done(done_v[3]), .ans(a3), .borrow(brw_v[3]));

    function automatic logic [7:0] ans_of(input int i);
        case (i)
            0:       return a0;
            1:       return a1;
            2:       return {3'b000, a2};
            default: return {4'b0000, a3};
        endcase
    endfunction

    function automatic int width_of(input int i);
        case (i)
            0, 1:    return 8;
            2:       return 5;
            default: return 4;
        endcase
    endfunction

    function automatic int n_of(input int i);
        case (i)
            0:       return 8;
            1:       return 2;
            2:       return 5;
            default: return 2;
        endcase
    endfunction

    // Golden model: plain (W+1)-bit arithmetic, borrow is bit W of the wrapped difference.
    function automatic exp_t model(input int w, input logic [7:0] x, input logic [7:0] y, input logic b);
        exp_t       e;
        logic [8:0] full;
        logic [8:0] mask;
        full  = {1'b0, x} - {1'b0, y} - {8'b0, b};
        mask  = (9'd1 << w) - 9'd1;
        e.ans = full[7:0] & mask[7:0];
        e.brw = full[w];
`ifdef SERIAL_SUB_SAT_EN
        if (e.brw) e.ans = 8'h00;
`endif
        return e;
    endfunction

    task automatic drive_start(input int i, input logic [7:0] x, input logic [7:0] y, input logic b);
        X_d        = x;
        Y_d        = y;
        bin_d      = b;
        start_v[i] = 1'b1;
        sbq.push_back(model(width_of(i), x, y, b));
        @(negedge clk);
        start_v[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, output int cyc, output int busy_cnt);
        cyc      = 0;
        busy_cnt = 0;
        while (!done_v[i] && cyc < 50) begin
            if (busy_v[i]) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        start_v = 4'b0;
        X_d     = 8'h00;
        Y_d     = 8'h00;
        bin_d   = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy_v, done_v, brw_v} !== 12'h000) begin
            errors++;
            $display("FAIL reset_flags: got busy=%b done=%b borrow=%b expected all 0", busy_v, done_v, brw_v);
        end
        checks++;
        if ({a0, a1, a2, a3} !== 25'h0) begin
            errors++;
            $display("FAIL reset_ans: got %h %h %h %h expected 0", a0, a1, a2, a3);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int   cyc;
        int   bc;
        exp_t e;
        drive_start(0, 8'h5A, 8'h3C, 1'b0);
        wait_done(0, cyc, bc);
        e = sbq.pop_front();
        checks++;
        if (cyc != 8 || bc != 8) begin
            errors++;
            $display("FAIL basic_latency: got done_cyc=%0d busy_cyc=%0d expected 8/8", cyc, bc);
        end
        checks++;
        if (a0 !== e.ans || a0 !== 8'h1E || brw_v[0] !== e.brw) begin
            errors++;
            $display("FAIL basic_result: got ans=%h borrow=%b expected ans=1e borrow=%b", a0, brw_v[0], e.brw);
        end
        @(negedge clk);
        checks++;
        if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || a0 !== 8'h1E) begin
            errors++;
            $display("FAIL basic_hold: got done=%b busy=%b ans=%h expected 0 0 1e", done_v[0], busy_v[0], a0);
        end
    endtask

    task automatic test_borrow;
        int   cyc;
        int   bc;
        exp_t e;
        drive_start(0, 8'h00, 8'h01, 1'b0);
        wait_done(0, cyc, bc);
        e = sbq.pop_front();
        checks++;
        if (cyc != 8 || a0 !== e.ans || brw_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL borrow_wrap: got cyc=%0d ans=%h borrow=%b expected 8 %h 1", cyc, a0, brw_v[0], e.ans);
        end
        @(negedge clk);
    endtask

    task automatic test_digit4;
        int         cyc;
        int         bc;
        exp_t       e;
        logic [7:0] xs [2];
        logic [7:0] ea [2];
        logic       eb [2];
        xs[0] = 8'h10; ea[0] = 8'h00; eb[0] = 1'b0;
        xs[1] = 8'h0F; eb[1] = 1'b1;
`ifdef SERIAL_SUB_SAT_EN
        ea[1] = 8'h00;
`else
        ea[1] = 8'hFF;
`endif
        for (int k = 0; k < 2; k++) begin
            drive_start(1, xs[k], 8'h0F, 1'b1);
            wait_done(1, cyc, bc);
            e = sbq.pop_front();
            checks++;
            if (cyc != 2 || a1 !== ea[k] || a1 !== e.ans || brw_v[1] !== eb[k]) begin
                errors++;
                $display("FAIL digit4_%0d: got cyc=%0d ans=%h borrow=%b expected 2 %h %b",
                         k, cyc, a1, brw_v[1], ea[k], eb[k]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_start;
        int   cyc;
        int   bc;
        exp_t e;
        drive_start(0, 8'h80, 8'h01, 1'b0);
        @(negedge clk);
        X_d        = 8'hFF;
        Y_d        = 8'hFF;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0, cyc, bc);
        e = sbq.pop_front();
        checks++;
        if (cyc != 6 || a0 !== 8'h7F || a0 !== e.ans || brw_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start: got cyc=%0d ans=%h borrow=%b expected 6 7f 0", cyc, a0, brw_v[0]);
        end
        drive_start(0, 8'h03, 8'h01, 1'b0);
        wait_done(0, cyc, bc);
        e = sbq.pop_front();
        checks++;
        if (cyc != 8 || a0 !== 8'h02 || a0 !== e.ans || brw_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done: got cyc=%0d ans=%h borrow=%b expected 8 02 0", cyc, a0, brw_v[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midrun;
        int   cyc;
        int   bc;
        int   dones;
        exp_t e;
        drive_start(0, 8'hC3, 8'h11, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || a0 !== 8'h00 || brw_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b done=%b ans=%h borrow=%b expected all 0",
                     busy_v[0], done_v[0], a0, brw_v[0]);
        end
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done_v[0]) dones++;
        end
        checks++;
        if (dones != 0 || a0 !== 8'h00 || busy_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done: got dones=%0d ans=%h busy=%b expected 0 00 0", dones, a0, busy_v[0]);
        end
        drive_start(0, 8'h40, 8'h15, 1'b1);
        wait_done(0, cyc, bc);
        e = sbq.pop_front();
        checks++;
        if (cyc != 8 || a0 !== e.ans || brw_v[0] !== e.brw) begin
            errors++;
            $display("FAIL after_reset: got cyc=%0d ans=%h borrow=%b expected 8 %h %b",
                     cyc, a0, brw_v[0], e.ans, e.brw);
        end
        @(negedge clk);
    endtask

    task automatic test_sweep;
        int         cyc;
        int         bc;
        int         w;
        exp_t       e;
        logic [7:0] xv;
        logic [7:0] yv;
        for (int i = 2; i < 4; i++) begin
            w = width_of(i);
            for (int x = 0; x < (1 << w); x++) begin
                for (int y = 0; y < (1 << w); y++) begin
                    for (int b = 0; b < 2; b++) begin
                        xv = 8'(x);
                        yv = 8'(y);
                        drive_start(i, xv, yv, b[0]);
                        wait_done(i, cyc, bc);
                        e = sbq.pop_front();
                        checks++;
                        if (cyc != n_of(i) || ans_of(i) !== e.ans || brw_v[i] !== e.brw) begin
                            errors++;
                            $display("FAIL sweep_w%0d x=%h y=%h b=%0d: got cyc=%0d ans=%h borrow=%b expected %0d %h %b",
                                     w, xv, yv, b, cyc, ans_of(i), brw_v[i], n_of(i), e.ans, e.brw);
                        end
                    end
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_digit4();
        test_ignore_start();
        test_reset_midrun();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
